// File: rtl/mips_multicycle.sv
// Multicycle MIPS-subset core with a single unified memory port.
// FETCH/DECODE/EXEC/MEM/WB/TRAP; every instruction re-enters FETCH on retire.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic        SLTU_EN  = 1'b1,
  parameter logic        BNE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instret,
  output logic        trap
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR     = 6'b001000;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [5:0] F_SLTU   = 6'b101011;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_tgt;
  logic [31:0] r_alu;
  logic [31:0] r_mdr;
  logic        r_run;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_sext;
  logic [31:0] w_pc4;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic        w_rtype;
  logic        w_jr;
  logic        w_addi;
  logic        w_ori;
  logic        w_lui;
  logic        w_lw;
  logic        w_sw;
  logic        w_beq;
  logic        w_bne;
  logic        w_j;
  logic        w_jal;
  logic        w_legal;
  logic        w_ctl;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_alu;
  logic [31:0] w_npc;
  logic        w_rf_we;
  logic [4:0]  w_rf_wa;
  logic [31:0] w_rf_wd;

  assign w_op     = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_funct  = r_ir[5:0];
  assign w_imm    = r_ir[15:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_pc4    = r_pc + 32'd4;
  assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : r_rf[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : r_rf[w_rt];

  always_comb begin
    w_rtype = 1'b0;
    w_jr    = 1'b0;
    w_addi  = 1'b0;
    w_ori   = 1'b0;
    w_lui   = 1'b0;
    w_lw    = 1'b0;
    w_sw    = 1'b0;
    w_beq   = 1'b0;
    w_bne   = 1'b0;
    w_j     = 1'b0;
    w_jal   = 1'b0;
    case (w_op)
      OP_R: begin
        case (w_funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_SLT, F_SLTU: w_rtype = 1'b1;
          F_JR:    w_jr = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: w_addi = 1'b1;
      OP_ORI:  w_ori = 1'b1;
      OP_LUI:  w_lui = 1'b1;
      OP_LW:   w_lw  = 1'b1;
      OP_SW:   w_sw  = 1'b1;
      OP_BEQ:  w_beq = 1'b1;
      OP_BNE:  w_bne = BNE_EN;
      OP_J:    w_j   = 1'b1;
      OP_JAL:  w_jal = 1'b1;
      default: ;
    endcase
  end

  assign w_ctl   = w_beq | w_bne | w_j | w_jal | w_jr;
  assign w_legal = w_ctl | w_rtype | w_addi | w_ori
                 | w_lui | w_lw | w_sw;

  assign w_slt  = $signed(r_a) < $signed(r_b);
  assign w_sltu = SLTU_EN ? (r_a < r_b) : w_slt;

  always_comb begin
    w_alu = r_a + w_sext;
    if (w_rtype) begin
      case (w_funct)
        F_SUB, F_SUBU: w_alu = r_a - r_b;
        F_AND:  w_alu = r_a & r_b;
        F_OR:   w_alu = r_a | r_b;
        F_SLT:  w_alu = {31'd0, w_slt};
        F_SLTU: w_alu = {31'd0, w_sltu};
        default: w_alu = r_a + r_b;
      endcase
    end else if (w_ori) begin
      w_alu = r_a | {16'd0, w_imm};
    end else if (w_lui) begin
      w_alu = {w_imm, 16'd0};
    end
  end

  always_comb begin
    w_npc = w_pc4;
    if (w_beq && (r_a == r_b))
      w_npc = r_tgt;
    else if (w_bne && (r_a != r_b))
      w_npc = r_tgt;
    else if (w_j || w_jal)
      w_npc = {w_pc4[31:28], r_ir[25:0], 2'b00};
    else if (w_jr)
      w_npc = r_a;
  end

  // JAL links in EXEC; everything else writes back in WB.
  always_comb begin
    w_rf_we = 1'b0;
    w_rf_wa = 5'd0;
    w_rf_wd = 32'd0;
    if (r_state == S_EXEC && w_jal) begin
      w_rf_we = 1'b1;
      w_rf_wa = 5'd31;
      w_rf_wd = w_pc4;
    end else if (r_state == S_WB) begin
      w_rf_we = 1'b1;
      w_rf_wa = w_rtype ? w_rd : w_rt;
      w_rf_wd = w_lw ? r_mdr : r_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rf_we && (w_rf_wa != 5'd0))
      r_rf[w_rf_wa] <= w_rf_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_tgt   <= 32'd0;
      r_alu   <= 32'd0;
      r_mdr   <= 32'd0;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (r_run && mem_ready) begin
            r_ir    <= mem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= w_rs_val;
          r_b     <= w_rt_val;
          r_tgt   <= w_pc4 + {w_sext[29:0], 2'b00};
          r_state <= w_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_ctl) begin
            r_pc    <= w_npc;
            r_state <= S_FETCH;
          end else if (w_lw || w_sw) begin
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_mdr <= mem_rdata;
            if (w_sw) begin
              r_pc    <= w_pc4;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_pc    <= w_pc4;
          r_state <= S_FETCH;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = (r_state == S_FETCH && r_run)
                   || (r_state == S_MEM);
  assign mem_we    = (r_state == S_MEM) && w_sw;
  assign mem_addr  = (r_state == S_MEM) ? r_alu : r_pc;
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign trap      = (r_state == S_TRAP);
  assign instret   = (r_state == S_WB)
                   || (r_state == S_EXEC && w_ctl)
                   || (r_state == S_MEM && w_sw && mem_ready);

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: two cores (default and SLTU/BNE off)
// each on its own word memory with per-request programmable wait states.
module tb_mips_multicycle;

  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req [2];
  logic        we  [2];
  logic        rdy [2];
  logic        ins [2];
  logic        tr  [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rd   [2];
  logic [31:0] pcv  [2];

  mips_multicycle u0 (
    .clk(clk), .reset(rst[0]),
    .mem_req(req[0]), .mem_we(we[0]),
    .mem_addr(addr[0]), .mem_wdata(wd[0]),
    .mem_rdata(rd[0]), .mem_ready(rdy[0]),
    .pc(pcv[0]), .instret(ins[0]), .trap(tr[0])
  );

  mips_multicycle #(.SLTU_EN(1'b0), .BNE_EN(1'b0)) u1 (
    .clk(clk), .reset(rst[1]),
    .mem_req(req[1]), .mem_we(we[1]),
    .mem_addr(addr[1]), .mem_wdata(wd[1]),
    .mem_rdata(rd[1]), .mem_ready(rdy[1]),
    .pc(pcv[1]), .instret(ins[1]), .trap(tr[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [2][256];
  int          wcnt [2];
  int          ridx [2];
  int          dly  [2];
  int          dly_idx [2];
  logic        pw [2];
  logic [7:0]  pa [2];
  logic [31:0] pd [2];

  logic [31:0] exp_q [$];

  // Memory: ready is raised at a negedge; a write is committed at the
  // following negedge, i.e. only once the core has taken the ready edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst[k]) begin
        rdy[k] = 1'b0; wcnt[k] = 0; ridx[k] = 0; pw[k] = 1'b0;
      end else begin
        if (rdy[k]) begin
          if (pw[k]) mem[k][pa[k]] = pd[k];
          ridx[k]++;
          wcnt[k] = 0;
        end
        rdy[k] = 1'b0;
        pw[k]  = 1'b0;
        if (req[k]) begin
          if (wcnt[k] >= ((ridx[k] == dly_idx[k]) ? dly[k] : 0)) begin
            rdy[k] = 1'b1;
            rd[k]  = mem[k][addr[k][9:2]];
            pw[k]  = we[k];
            pa[k]  = addr[k][9:2];
            pd[k]  = wd[k];
          end else begin
            wcnt[k]++;
          end
        end
      end
    end
  end

  int          cyc;
  bit          started;
  bit          prev_ins;
  int          obs_cyc [$];
  logic [31:0] obs_pc  [$];

  always @(negedge clk) begin
    #1;
    if (!rst[0]) begin
      started = 0; cyc = 0; prev_ins = 0;
      obs_cyc.delete(); obs_pc.delete();
    end else begin
      if (!started && req[0]) started = 1;
      if (started) cyc++;
      if (prev_ins) obs_pc.push_back(pcv[0]);
      if (ins[0]) obs_cyc.push_back(cyc);
      prev_ins = ins[0];
    end
  end

  function automatic logic [31:0] fi(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] fr(input logic [5:0] fn,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rdd);
    return {6'd0, rs, rt, rdd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] fj(input logic [5:0] op,
    input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int k);
    rst[k] = 1'b0;
    dly[k] = 0;
    dly_idx[k] = -1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[k][i] = 32'hFC00_0000;
  endtask

  task automatic run_to_trap(input int k);
    int n = 0;
    while (tr[k] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    check($sformatf("trap%0d", k), 32'(tr[k]), 32'd1);
    check($sformatf("trap_req%0d", k), 32'(req[k]), 32'd0);
  endtask

  logic [31:0] e;
  logic [31:0] lw_word;

  initial begin
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    hold(1);

    // ALU sequence and retire timing
    hold(0);
    mem[0][0] = fi(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[0][1] = fi(OP_ADDI, 5'd0, 5'd2, 16'd7);
    mem[0][2] = fr(F_ADD, 5'd1, 5'd2, 5'd3);
    mem[0][3] = fi(OP_SW, 5'd0, 5'd3, 16'h0100);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd16);
    #1;
    check("rst_req", 32'(req[0]), 32'd0);
    check("rst_we", 32'(we[0]), 32'd0);
    check("rst_instret", 32'(ins[0]), 32'd0);
    check("rst_trap", 32'(tr[0]), 32'd0);
    check("rst_pc", pcv[0], 32'h0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("first_fetch_req", 32'(req[0]), 32'd1);
    check("first_fetch_addr", addr[0], 32'h0);
    run_to_trap(0);
    check("add_result", mem[0][64], 32'd12);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      check($sformatf("instret_cyc%0d", i),
            (i < obs_cyc.size()) ? 32'(obs_cyc[i]) : 32'hFFFF_FFFF, e);
    end

    // LW with three wait cycles on the data access
    hold(0);
    lw_word = fi(OP_LW, 5'd0, 5'd4, 16'd0);
    mem[0][0] = lw_word;
    mem[0][1] = fi(OP_SW, 5'd0, 5'd4, 16'h0100);
    dly[0] = 3;
    dly_idx[0] = 1;
    @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #2;
      if (c >= 4 && c <= 7) begin
        check($sformatf("lw_wait_addr%0d", c), addr[0], 32'h0);
        check($sformatf("lw_wait_we%0d", c), 32'(we[0]), 32'd0);
        check($sformatf("lw_wait_req%0d", c), 32'(req[0]), 32'd1);
      end
      if (c == 8) check("lw_retire_c8", 32'(ins[0]), 32'd1);
    end
    run_to_trap(0);
    check("lw_data", mem[0][64], lw_word);

    // Branches and jumps
    hold(0);
    mem[0][0]  = fj(OP_J, 32'h10);
    mem[0][1]  = fi(OP_BNE, 5'd0, 5'd0, 16'd8);
    mem[0][2]  = fi(OP_ADDI, 5'd0, 5'd5, 16'd1);
    mem[0][3]  = fi(OP_BNE, 5'd5, 5'd0, 16'd4);
    mem[0][4]  = fi(OP_BEQ, 5'd0, 5'd0, 16'hFFFC);
    mem[0][8]  = fj(OP_JAL, 32'h40);
    mem[0][9]  = fi(OP_SW, 5'd0, 5'd31, 16'h0100);
    mem[0][16] = fr(F_JR, 5'd31, 5'd0, 5'd0);
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h04);
    exp_q.push_back(32'h08);
    exp_q.push_back(32'h0C);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h24);
    exp_q.push_back(32'h28);
    @(negedge clk);
    rst[0] = 1'b1;
    run_to_trap(0);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      check($sformatf("next_pc%0d", i),
            (i < obs_pc.size()) ? obs_pc[i] : 32'hFFFF_FFFF, e);
    end
    check("j_cycles",
          (obs_cyc.size() > 0) ? 32'(obs_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
    check("jal_link", mem[0][64], 32'h24);
    check("trap_pc", pcv[0], 32'h28);

    // Compare flavours, immediates, $0 and illegal decode on both cores
    hold(0);
    for (int k = 0; k < 2; k++) begin
      mem[k][0]  = fi(OP_ADDI, 5'd0, 5'd1, 16'hFFFF);
      mem[k][1]  = fi(OP_ADDI, 5'd0, 5'd2, 16'd1);
      mem[k][2]  = fr(F_SLTU, 5'd1, 5'd2, 5'd3);
      mem[k][3]  = fi(OP_SW, 5'd0, 5'd3, 16'h0100);
      mem[k][4]  = fr(F_SLT, 5'd1, 5'd2, 5'd3);
      mem[k][5]  = fi(OP_SW, 5'd0, 5'd3, 16'h0104);
      mem[k][6]  = fi(OP_ADDI, 5'd0, 5'd0, 16'd9);
      mem[k][7]  = fi(OP_SW, 5'd0, 5'd0, 16'h0108);
      mem[k][8]  = fi(OP_ORI, 5'd0, 5'd6, 16'h8001);
      mem[k][9]  = fi(OP_LUI, 5'd0, 5'd7, 16'h1234);
      mem[k][10] = fr(F_OR, 5'd6, 5'd7, 5'd8);
      mem[k][11] = fi(OP_SW, 5'd0, 5'd8, 16'h010C);
      mem[k][12] = fr(F_SUB, 5'd2, 5'd1, 5'd9);
      mem[k][13] = fi(OP_SW, 5'd0, 5'd9, 16'h0110);
      mem[k][66] = 32'hDEAD_BEEF;
    end
    mem[0][14] = 32'h0000_0000;
    mem[1][14] = fi(OP_BNE, 5'd0, 5'd0, 16'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h1234_8001);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'h1234_8001);
    exp_q.push_back(32'd2);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    run_to_trap(0);
    run_to_trap(1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) begin
        e = exp_q.pop_front();
        check($sformatf("dut%0d_word%0d", k, i), mem[k][64 + i], e);
      end
      check($sformatf("dut%0d_trap_pc", k), pcv[k], 32'h38);
    end
    hold(1);

    // Reset during a stalled store
    hold(0);
    mem[0][0]  = fi(OP_ADDI, 5'd0, 5'd1, 16'h0055);
    mem[0][1]  = fi(OP_SW, 5'd0, 5'd1, 16'h0100);
    mem[0][64] = 32'hAAAA_AAAA;
    dly[0] = 10;
    dly_idx[0] = 2;
    @(negedge clk);
    rst[0] = 1'b1;
    for (int n = 0; n < 50 && we[0] !== 1'b1; n++) @(negedge clk);
    check("sw_stall_seen", 32'(we[0]), 32'd1);
    @(negedge clk);
    #2;
    rst[0] = 1'b0;
    #1;
    check("abort_req", 32'(req[0]), 32'd0);
    check("abort_we", 32'(we[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_pc", pcv[0], 32'h0);
    check("abort_nowrite", mem[0][64], 32'hAAAA_AAAA);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("restart_req", 32'(req[0]), 32'd1);
    check("restart_addr", addr[0], 32'h0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
